// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: ROM read, palette resolve, transparency and damage-flash colour over a fixed 3-stage pipeline.
// Optional per-frame opaque pixel counter enabled by defining SPRITE_PIXEL_COUNT_EN.
module sprite_pixel_fetch #(
  parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
  parameter logic [7:0]  FLASH_FRAMES    = 8'd32,
  parameter logic [3:0]  FLASH_PERIOD    = 4'd4,
  parameter logic [11:0] FLASH_RGB       = 12'hF00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        pix_valid_in,
  input  logic [8:0]  PixelX,
  input  logic [8:0]  PixelY,
  input  logic        is_obj,
  input  logic [12:0] Obj_address,
  input  logic [11:0] bg_rgb,
  output logic        rom_rd,
  output logic [12:0] rom_addr,
  input  logic [3:0]  rom_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data,
  input  logic        hit,
  output logic        pix_valid_out,
  output logic [8:0]  PixelX_out,
  output logic [8:0]  PixelY_out,
  output logic [11:0] rgb_out,
  output logic        flashing
`ifdef SPRITE_PIXEL_COUNT_EN
  ,
  output logic [15:0] opaque_count
`endif
);

  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_e;

  logic [3:1]        vld_pipe_q, vld_pipe_d;
  logic              rom_rd_q, rom_rd_d;
  logic [12:0]       rom_addr_q, rom_addr_d;
  logic [8:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d, s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic              s1_obj_q, s1_obj_d, s2_obj_q, s2_obj_d;
  logic [11:0]       s1_bg_q, s1_bg_d, s2_bg_q, s2_bg_d;
  logic [8:0]        x_out_q, x_out_d, y_out_q, y_out_d;
  logic [11:0]       rgb_q, rgb_d;
  logic [15:0][11:0] pal_q, pal_d;
  logic [2:0]        sync_q, sync_d;
  logic              fe, opaque;
  state_e            state_q, state_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [3:0]        phase_cnt_q, phase_cnt_d;
  logic              flashing_q, flashing_d;
`ifdef SPRITE_PIXEL_COUNT_EN
  logic              s3_opq_q, s3_opq_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc, ocount_q, ocount_d;
`endif

  always_comb begin
    vld_pipe_d = {vld_pipe_q[2:1], pix_valid_in};
    rom_rd_d   = pix_valid_in & is_obj;
    rom_addr_d = rom_rd_d ? Obj_address : rom_addr_q;
    s1_x_d = PixelX;   s1_y_d = PixelY;   s1_obj_d = is_obj;   s1_bg_d = bg_rgb;
    s2_x_d = s1_x_q;   s2_y_d = s1_y_q;   s2_obj_d = s1_obj_q; s2_bg_d = s1_bg_q;

    // rom_data is live during S2, so transparency and lookup resolve straight off the bus
    opaque  = s2_obj_q && (rom_data != TRANSPARENT_IDX);
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    rgb_d   = rgb_q;
    if (vld_pipe_q[2]) begin
      x_out_d = s2_x_q;
      y_out_d = s2_y_q;
      if (!opaque)                rgb_d = s2_bg_q;
      else if (state_q == FLASH_ON) rgb_d = FLASH_RGB;
      else                        rgb_d = pal_q[rom_data];
    end

    pal_d = pal_q;
    if (pal_we) pal_d[pal_idx] = pal_data;

    sync_d = {sync_q[1:0], frame_clk};
    fe     = sync_q[1] & ~sync_q[2];

    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;
    if (hit) begin
      state_d     = FLASH_ON;
      frame_cnt_d = FLASH_FRAMES;
      phase_cnt_d = FLASH_PERIOD;
    end else if (fe && state_q != IDLE) begin
      frame_cnt_d = frame_cnt_q - 8'd1;
      phase_cnt_d = phase_cnt_q - 4'd1;
      if (frame_cnt_d == 8'd0) begin
        state_d = IDLE;
      end else if (phase_cnt_d == 4'd0) begin
        state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
        phase_cnt_d = FLASH_PERIOD;
      end
    end
    flashing_d = (state_d != IDLE);

`ifdef SPRITE_PIXEL_COUNT_EN
    s3_opq_d = vld_pipe_q[2] & opaque;
    cnt_inc  = (vld_pipe_q[3] && s3_opq_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    cnt_d    = fe ? 16'd0 : cnt_inc;
    ocount_d = fe ? cnt_inc : ocount_q;
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_pipe_q  <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      s1_x_q <= '0; s1_y_q <= '0; s1_obj_q <= 1'b0; s1_bg_q <= '0;
      s2_x_q <= '0; s2_y_q <= '0; s2_obj_q <= 1'b0; s2_bg_q <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      rgb_q       <= '0;
      pal_q       <= '0;
      sync_q      <= '0;
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      phase_cnt_q <= '0;
      flashing_q  <= 1'b0;
`ifdef SPRITE_PIXEL_COUNT_EN
      s3_opq_q    <= 1'b0;
      cnt_q       <= '0;
      ocount_q    <= '0;
`endif
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      s1_x_q <= s1_x_d; s1_y_q <= s1_y_d; s1_obj_q <= s1_obj_d; s1_bg_q <= s1_bg_d;
      s2_x_q <= s2_x_d; s2_y_q <= s2_y_d; s2_obj_q <= s2_obj_d; s2_bg_q <= s2_bg_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      rgb_q       <= rgb_d;
      pal_q       <= pal_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      flashing_q  <= flashing_d;
`ifdef SPRITE_PIXEL_COUNT_EN
      s3_opq_q    <= s3_opq_d;
      cnt_q       <= cnt_d;
      ocount_q    <= ocount_d;
`endif
    end
  end

  assign rom_rd        = rom_rd_q;
  assign rom_addr      = rom_addr_q;
  assign pix_valid_out = vld_pipe_q[3];
  assign PixelX_out    = x_out_q;
  assign PixelY_out    = y_out_q;
  assign rgb_out       = rgb_q;
  assign flashing      = flashing_q;
`ifdef SPRITE_PIXEL_COUNT_EN
  assign opaque_count  = ocount_q;
`endif

endmodule
